// File: rtl/sel_mux_pipe_stage_if.sv
// sel_mux_pipe_stage_if: input/output handshake bundle of the registered select stage
interface sel_mux_pipe_stage_if #(
    parameter int WIDTH = 5,
    parameter int N_IN  = 2,
    parameter int SEL_W = 1
) ();
    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_sel_err;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            err_count;
    modport master (
        output in_data, sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid, err_count
    );
    modport slave (
        input  in_data, sel, in_valid, out_ready,
        output in_ready, out_data, out_sel_err, out_valid, err_count
    );
endinterface

// File: rtl/sel_mux_pipe_stage.sv
// sel_mux_pipe_stage: N-input registered select stage behind a 2-entry skid buffer
// In_Ready comes from registered state only, so it never depends on Out_Ready.
module sel_mux_pipe_stage #(
    parameter int WIDTH = 5,
    parameter int N_IN  = 2,
    parameter int SEL_W = 1
) (
    input logic clk,
    input logic reset,
    sel_mux_pipe_stage_if.slave bus
);
    localparam int NW = 2 ** SEL_W;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] words [NW];
    logic [NW-1:0] oob;
    logic [WIDTH-1:0] main_d, skid_d, sel_d;
    logic main_e, skid_e, sel_e, in_ready, out_valid, accept, pop, load_main;
    logic [7:0] err_cnt;
    // Unused select codes map to a zero word flagged as out of range
    for (genvar k = 0; k < NW; k++) begin : g_w
        if (k < N_IN) begin : g_in
            assign words[k] = bus.in_data[k*WIDTH +: WIDTH];
            assign oob[k] = 1'b0;
        end else begin : g_oob
            assign words[k] = '0;
            assign oob[k] = 1'b1;
        end
    end
    assign sel_d = words[bus.sel];
    assign sel_e = oob[bus.sel];
    assign in_ready = state != FULL;
    assign out_valid = state != EMPTY;
    assign accept = bus.in_valid & in_ready;
    assign pop = out_valid & bus.out_ready;
    assign load_main = state == FULL ? pop : accept & (state == EMPTY | pop);
    assign bus.in_ready = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data = main_d;
    assign bus.out_sel_err = main_e;
    assign bus.err_count = err_cnt;
    always_comb begin
        state_n = state;
        case (state)
            EMPTY:   state_n = accept ? ONE : EMPTY;
            ONE:     state_n = (accept & !pop) ? FULL : (!accept & pop) ? EMPTY : ONE;
            FULL:    state_n = pop ? ONE : FULL;
            default: state_n = EMPTY;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else state <= state_n;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_d  <= '0;
            main_e  <= 1'b0;
            skid_d  <= '0;
            skid_e  <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            if (load_main) begin
                main_d <= state == FULL ? skid_d : sel_d;
                main_e <= state == FULL ? skid_e : sel_e;
            end
            if (accept & state == ONE & !pop) begin
                skid_d <= sel_d;
                skid_e <= sel_e;
            end
            if (accept & sel_e & err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule
